// File: rtl/idu_stage_if.sv
// Handshake and decoded-record bundle between the fetch side, the decode stage and
// the downstream consumer.
interface idu_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_rs1,
           out_rs2, out_rd, out_imm, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_func3, out_func7, out_rs1,
           out_rs2, out_rd, out_imm, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/idu_stage.sv
// RV instruction decode stage: decodes at the input and queues complete decoded
// records in a small FIFO whose head drives the outputs.
module idu_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  idu_stage_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } rec_t;

  rec_t            dec;
  rec_t            head;
  rec_t            mem [DEPTH];
  logic [31:0]     imm32;
  logic [31:0]     inst;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            alive_reg;
  logic            push;
  logic            pop;

  assign inst = bus.in_inst;

  always_comb begin
    dec         = '0;
    imm32       = '0;
    dec.opcode  = inst[6:0];
    dec.func3   = inst[14:12];
    dec.func7   = inst[31:25];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (inst[6:0])
      7'b0110011, 7'b0111011: dec.fmt = FMT_R;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    // Compressed/odd encodings never reach a valid 32-bit format.
    if (inst[1:0] != 2'b11) begin
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
      imm32       = '0;
    end
    // Replicate then overwrite the low word so XLEN = 32 needs no special case.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = alive_reg && (count_reg < CW'(DEPTH));
  assign bus.out_valid = (count_reg != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      alive_reg  <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= dec;
  end

  // Gating by out_valid keeps data outputs at zero while empty or in reset.
  assign head            = bus.out_valid ? mem[rd_ptr_reg] : '0;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_func3   = head.func3;
  assign bus.out_func7   = head.func7;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_rd      = head.rd;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_illegal = head.illegal;
  assign bus.out_pc      = mem_pc_reg_sel();

  // PC travels alongside the decoded record in its own array.
  logic [XLEN-1:0] pc_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !flush) pc_mem[wr_ptr_reg] <= bus.in_pc;
  end

  function automatic logic [XLEN-1:0] mem_pc_reg_sel();
    return bus.out_valid ? pc_mem[rd_ptr_reg] : '0;
  endfunction
endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: a decode vector table plus hand-written
// backpressure, streaming, flush and reset sequences.
module tb_idu_stage;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int NVEC  = 9;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  idu_stage_if #(.XLEN(XLEN)) bus ();

  idu_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //          inst          pc                      opc    fmt  rd     rs1    rs2    f3    f7      imm                      ill
    vecs[0] = '{32'hFE208EE3, 64'h0000_0000_8000_0000, 7'h63, 3'd3, 5'd29, 5'd1, 5'd2,  3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[1] = '{32'h001000EF, 64'h0000_0000_8000_0004, 7'h6F, 3'd5, 5'd1,  5'd0, 5'd1,  3'd0, 7'h00, 64'h0000_0000_0000_0800, 1'b0};
    vecs[2] = '{32'h800002B7, 64'h0000_0000_8000_0008, 7'h37, 3'd4, 5'd5,  5'd0, 5'd0,  3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[3] = '{32'h0020A423, 64'h0000_0000_8000_000C, 7'h23, 3'd2, 5'd8,  5'd1, 5'd2,  3'd2, 7'h00, 64'h0000_0000_0000_0008, 1'b0};
    vecs[4] = '{32'hFFF00093, 64'h0000_0000_8000_0010, 7'h13, 3'd1, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{32'h002081B3, 64'h0000_0000_8000_0014, 7'h33, 3'd0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 64'h0000_0000_0000_0000, 1'b0};
    vecs[6] = '{32'h00000000, 64'h0000_0000_8000_0018, 7'h00, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 64'h0000_0000_0000_0000, 1'b1};
    vecs[7] = '{32'h0000007F, 64'h0000_0000_8000_001C, 7'h7F, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 64'h0000_0000_0000_0000, 1'b1};
    vecs[8] = '{32'hFFC12283, 64'h1234_5678_9ABC_DEF0, 7'h03, 3'd1, 5'd5,  5'd2, 5'd28, 3'd2, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0000_0013;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check("reset_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("reset_out_pc", bus.out_pc, 64'd0);

    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", 64'(bus.in_ready), 64'd0);
    step();
    check("ready_after_first_edge", 64'(bus.in_ready), 64'd1);

    // Decode table: push one word, check the head next cycle, then pop it.
    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = vecs[i].pc;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("vec_out_valid", 64'(bus.out_valid), 64'd1);
      check("vec_opcode", 64'(bus.out_opcode), 64'(vecs[i].opc));
      check("vec_fmt", 64'(bus.out_fmt), 64'(vecs[i].fmt));
      check("vec_rd", 64'(bus.out_rd), 64'(vecs[i].rd));
      check("vec_rs1", 64'(bus.out_rs1), 64'(vecs[i].rs1));
      check("vec_rs2", 64'(bus.out_rs2), 64'(vecs[i].rs2));
      check("vec_func3", 64'(bus.out_func3), 64'(vecs[i].f3));
      check("vec_func7", 64'(bus.out_func7), 64'(vecs[i].f7));
      check("vec_imm", bus.out_imm, vecs[i].imm);
      check("vec_illegal", 64'(bus.out_illegal), 64'(vecs[i].ill));
      check("vec_pc", bus.out_pc, vecs[i].pc);
      $display("vec %0d inst %h pc %h -> fmt %0d imm %h illegal %0d",
               i, vecs[i].inst, vecs[i].pc, bus.out_fmt, bus.out_imm, bus.out_illegal);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("vec_drained", 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: three offered words, only two fit.
    bus.in_inst  = 32'hFFF00093;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h1000;
    step();
    bus.in_pc = 64'h1004;
    step();
    bus.in_pc = 64'h1008;
    @(negedge clk);
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head_a", bus.out_pc, 64'h1000);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_head_still_a", bus.out_pc, 64'h1000);
    bus.out_ready = 1'b1;
    #1;
    check("bp_full_pop_ready", 64'(bus.in_ready), 64'd0);
    step();
    @(negedge clk);
    check("bp_pop_valid_b", 64'(bus.out_valid), 64'd1);
    check("bp_pop_head_b", bus.out_pc, 64'h1004);
    step();
    @(negedge clk);
    check("bp_third_absent", 64'(bus.out_valid), 64'd0);
    $display("backpressure sequence done");

    // Streaming: one push and one pop every cycle for 8 records.
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_inst = vecs[k].inst;
      bus.in_pc   = 64'h2000 + 64'(4 * k);
      step();
      @(negedge clk);
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_pc", bus.out_pc, 64'h2000 + 64'(4 * k));
      check("stream_fmt", 64'(bus.out_fmt), 64'(vecs[k].fmt));
      check("stream_ready", 64'(bus.in_ready), 64'd1);
      $display("stream %0d pc %h", k, bus.out_pc);
    end
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    check("stream_drained", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Flush while full with a concurrent offered word.
    bus.in_inst  = 32'h002081B3;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h3000;
    step();
    bus.in_pc = 64'h3004;
    step();
    bus.in_pc     = 64'h3008;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_full_valid", 64'(bus.out_valid), 64'd0);
    check("flush_full_ready", 64'(bus.in_ready), 64'd1);
    step();
    @(negedge clk);
    check("flush_full_stays_empty", 64'(bus.out_valid), 64'd0);

    // Flush with one entry while a push is actually accepted.
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h4000;
    step();
    bus.in_pc = 64'h4004;
    flush     = 1'b1;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_push_ignored", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h5000;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_head", bus.out_pc, 64'h5000);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_flush_drained", 64'(bus.out_valid), 64'd0);
    $display("flush sequences done");

    // Reset asserted mid-stream with two entries queued.
    bus.in_inst  = 32'hFE208EE3;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h6000;
    step();
    bus.in_pc = 64'h6004;
    step();
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_pc", bus.out_pc, 64'd0);
    check("midrst_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("midrst_out_imm", bus.out_imm, 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_release_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("midrst_ready_rises", 64'(bus.in_ready), 64'd1);
    check("midrst_no_old_entry", 64'(bus.out_valid), 64'd0);
    bus.in_inst  = 32'h001000EF;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h7000;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_new_head", bus.out_pc, 64'h7000);
    check("midrst_new_fmt", 64'(bus.out_fmt), 64'd5);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("midrst_final_empty", 64'(bus.out_valid), 64'd0);
    $display("reset sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
